// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_cpu_pkg: shared state, opcode and ALU-control encodings for the core.
// Revision 1.0
// ----------------------------------------------------------------------------
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_ctl_e alu_ctl_for(input logic [5:0] op, input logic [5:0] fn);
    alu_ctl_e ctl;
    ctl = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  ctl = ALU_SUB;
        FN_AND:  ctl = ALU_AND;
        FN_OR:   ctl = ALU_OR;
        FN_SLT:  ctl = ALU_SLT;
        default: ctl = ALU_ADD;
      endcase
    end else if (op == OP_BEQ) begin
      ctl = ALU_SUB;
    end
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_cpu_core_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_cpu_core_if: instruction ROM port and handshaked data-memory bus.
// Revision 1.0
// ----------------------------------------------------------------------------
interface multicycle_cpu_core_if #(
  parameter int N    = 8,
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [N-1:0]    dmem_addr;
  logic [N-1:0]    dmem_wdata;
  logic [N-1:0]    dmem_rdata;
  logic            dmem_ready;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, dmem_rdata, dmem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_regfile: NREG x N register file, two async reads + debug read, one write.
// Revision 1.0
// ----------------------------------------------------------------------------
module mc_regfile #(
  parameter  int N    = 8,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  input  logic [RW-1:0] dbg_ra_i,
  output logic [N-1:0]  rd1_o,
  output logic [N-1:0]  rd2_o,
  output logic [N-1:0]  dbg_rd_o,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [N-1:0]  wd_i
);

  logic [N-1:0] regs_q [NREG];

  // R0 is never written, so it holds its cleared value forever.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o    = (ra1_i    == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o    = (ra2_i    == '0) ? '0 : regs_q[ra2_i];
  assign dbg_rd_o = (dbg_ra_i == '0) ? '0 : regs_q[dbg_ra_i];

endmodule
`default_nettype wire

// File: rtl/multicycle_cpu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_cpu_core: FSM-sequenced MIPS-subset core with one shared ALU.
// Revision 1.0
// ----------------------------------------------------------------------------
module multicycle_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int NREG = 8,
  parameter  int PC_W = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_cpu_core_if.master bus,
  input  logic [RW-1:0]         dbg_ra,
  output logic [N-1:0]          dbg_rd,
  output logic [PC_W-1:0]       pc_out,
  output logic [2:0]            state_out,
  output logic                  instr_done,
  output logic                  illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    aluout_q, aluout_d, mdr_q, mdr_d;
  logic            illegal_q, illegal_d, done_q, done_d;

  logic [5:0]      w_dec_op, w_dec_fn, w_op, w_fn;
  logic [31:0]     w_imm_sx;
  logic [N-1:0]    w_imm, w_alu_b, w_alu_y, w_rd1, w_rd2, w_rf_wd;
  logic [PC_W-1:0] w_imm_pc, w_pc_inc;
  logic [RW-1:0]   w_rf_wa;
  logic            w_rf_we;
  alu_ctl_e        w_alu_ctl;
  logic            w_unused;

  // DECODE reads operands straight from the ROM word; later states use IR.
  assign w_dec_op = bus.imem_rdata[31:26];
  assign w_dec_fn = bus.imem_rdata[5:0];
  assign w_op     = ir_q[31:26];
  assign w_fn     = ir_q[5:0];
  assign w_imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};
  assign w_imm    = w_imm_sx[N-1:0];
  assign w_imm_pc = w_imm_sx[PC_W-1:0];
  assign w_pc_inc = pc_q + PC_W'(1);
  assign w_unused = ^{ir_q, w_imm_sx};

  mc_regfile #(.N(N), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra1_i    (bus.imem_rdata[21 +: RW]),
    .ra2_i    (bus.imem_rdata[16 +: RW]),
    .dbg_ra_i (dbg_ra),
    .rd1_o    (w_rd1),
    .rd2_o    (w_rd2),
    .dbg_rd_o (dbg_rd),
    .we_i     (w_rf_we),
    .wa_i     (w_rf_wa),
    .wd_i     (w_rf_wd)
  );

  assign w_rf_wa = (w_op == OP_RTYPE) ? ir_q[11 +: RW] : ir_q[16 +: RW];
  assign w_rf_wd = (w_op == OP_LW) ? mdr_q : aluout_q;

  assign w_alu_ctl = alu_ctl_for(w_op, w_fn);
  assign w_alu_b   = (w_op == OP_RTYPE) ? b_q : w_imm;

  always_comb begin
    w_alu_y = '0;
    case (w_alu_ctl)
      ALU_ADD: w_alu_y = a_q + w_alu_b;
      ALU_SUB: w_alu_y = a_q - w_alu_b;
      ALU_AND: w_alu_y = a_q & w_alu_b;
      ALU_OR:  w_alu_y = a_q | w_alu_b;
      ALU_SLT: w_alu_y = {{(N-1){1'b0}}, ($signed(a_q) < $signed(w_alu_b))};
      default: w_alu_y = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    w_rf_we   = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = bus.imem_rdata;
        a_d  = w_rd1;
        b_d  = w_rd2;
        if (w_dec_op == OP_J) begin
          pc_d    = bus.imem_rdata[PC_W-1:0];
          done_d  = 1'b1;
          state_d = S_FETCH;
        end else if (!is_legal(w_dec_op, w_dec_fn)) begin
          illegal_d = 1'b1;
          pc_d      = w_pc_inc;
          done_d    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluout_d = w_alu_y;
        if (w_op == OP_BEQ) begin
          pc_d    = (a_q == b_q) ? (w_pc_inc + w_imm_pc) : w_pc_inc;
          done_d  = 1'b1;
          state_d = S_FETCH;
        end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (w_op == OP_LW) begin
            mdr_d   = bus.dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = w_pc_inc;
            done_d  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_rf_we = 1'b1;
        pc_d    = w_pc_inc;
        done_d  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  // Address, data and direction come from registers, so they hold through MEM.
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == S_MEM);
  assign bus.dmem_we    = (w_op == OP_SW);
  assign bus.dmem_addr  = aluout_q;
  assign bus.dmem_wdata = b_q;

  assign pc_out     = pc_q;
  assign state_out  = state_q;
  assign instr_done = done_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multicycle_cpu_core: directed program run against the core, N=8 and N=16.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_multicycle_cpu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst2 = 1'b0;
  logic [2:0] dbg_ra = '0;
  logic [7:0] dbg_rd, pc_out;
  logic [2:0] state_out;
  logic       instr_done, illegal;

  logic [3:0]  dbg_ra2 = '0;
  logic [15:0] dbg_rd2;
  logic [7:0]  pc_out2;
  logic [2:0]  state_out2;
  logic        instr_done2, illegal2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rom [256];
  logic [7:0]  ram [256];
  int          ready_delay = 3;
  logic        hold_ready = 1'b0;
  int          wcnt = 0;

  int          cyc = 0;
  int          ndone = 0;
  int          done_cyc [64];
  logic [7:0]  done_pc  [64];

  always #5 clk = ~clk;

  multicycle_cpu_core_if #(.N(8), .PC_W(8)) bus ();
  multicycle_cpu_core #(.N(8), .NREG(8), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd),
    .pc_out(pc_out), .state_out(state_out), .instr_done(instr_done), .illegal(illegal)
  );

  multicycle_cpu_core_if #(.N(16), .PC_W(8)) bus16 ();
  multicycle_cpu_core #(.N(16), .NREG(16), .PC_W(8)) dut16 (
    .clk(clk), .rst(rst2), .bus(bus16), .dbg_ra(dbg_ra2), .dbg_rd(dbg_rd2),
    .pc_out(pc_out2), .state_out(state_out2), .instr_done(instr_done2), .illegal(illegal2)
  );

  // ROM / RAM models
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];
  assign bus.dmem_ready = bus.dmem_req && (wcnt == ready_delay) && !hold_ready;
  assign bus.dmem_rdata = ram[bus.dmem_addr];
  always @(posedge clk) begin
    if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) ram[bus.dmem_addr] <= bus.dmem_wdata;
    if (bus.dmem_req && !bus.dmem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // addi R15,R0,-2 at 0, then j 1 forever
  always @(posedge clk)
    bus16.imem_rdata <= (bus16.imem_addr == 8'd0) ? 32'h200FFFFE : 32'h08000001;
  assign bus16.dmem_ready = 1'b0;
  assign bus16.dmem_rdata = '0;

  always @(posedge clk) begin
    #1;
    cyc <= (!rst) ? 0 : cyc + 1;
    if (instr_done && ndone < 64) begin
      done_cyc[ndone] <= cyc + 1;
      done_pc[ndone]  <= pc_out;
      ndone           <= ndone + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rdreg(input int idx, output logic [31:0] v);
    dbg_ra = idx[2:0];
    #1;
    v = 32'(dbg_rd);
  endtask

  task automatic wait_done(input int k);
    for (int n = 0; n < 300 && ndone < k; n++) @(negedge clk);
    if (ndone < k) chk("timeout_retire", ndone, k);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, fn};
  endfunction

  initial begin
    logic [31:0] v, acc;
    int req_cnt, bad, base;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0]    = enc_i(6'b001000, 0, 1, 5);        // addi R1,R0,5
    rom[1]    = enc_i(6'b001000, 0, 2, 3);        // addi R2,R0,3
    rom[2]    = enc_r(1, 2, 3, 6'b100000);        // add R3,R1,R2
    rom[3]    = enc_r(2, 1, 4, 6'b100010);        // sub R4,R2,R1
    rom[4]    = enc_r(4, 0, 5, 6'b101010);        // slt R5,R4,R0
    rom[5]    = enc_i(6'b001000, 0, 6, 'hF0);     // addi R6,R0,0xF0
    rom[6]    = enc_i(6'b001000, 0, 7, 'h3C);     // addi R7,R0,0x3C
    rom[7]    = enc_r(6, 7, 5, 6'b100100);        // and R5,R6,R7
    rom[8]    = enc_r(6, 7, 4, 6'b100101);        // or R4,R6,R7
    rom[9]    = enc_i(6'b101011, 0, 3, 2);        // sw R3,2(R0)
    rom[10]   = enc_i(6'b100011, 0, 6, 2);        // lw R6,2(R0)
    rom[11]   = enc_i(6'b000100, 1, 2, 5);        // beq R1,R2,5
    rom[12]   = enc_i(6'b001000, 0, 0, 7);        // addi R0,R0,7
    rom[13]   = 32'hFC000000;                     // illegal opcode
    rom[14]   = 32'h0800002A;                     // j 0x2A
    rom[8'h2A] = enc_i(6'b000100, 1, 1, -1);      // beq R1,R1,-1

    repeat (3) @(negedge clk);
    chk("rst_pc", pc_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b1;
    rst2 = 1'b1;

    wait_done(3);
    chk("done_cyc0", done_cyc[0], 4);
    chk("done_cyc1", done_cyc[1], 8);
    chk("done_cyc2", done_cyc[2], 12);
    chk("pc_after_add", pc_out, 3);
    rdreg(3, v); chk("R3_add", v, 8);
    wait_done(4);
    rdreg(4, v); chk("R4_sub", v, 'hFE);
    wait_done(5);
    rdreg(5, v); chk("R5_slt", v, 1);
    wait_done(9);
    rdreg(5, v); chk("R5_and", v, 'h30);
    rdreg(4, v); chk("R4_or", v, 'hFC);

    req_cnt = 0; bad = 0;
    for (int n = 0; n < 40 && ndone < 10; n++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        req_cnt++;
        if (bus.dmem_addr !== 8'd2 || bus.dmem_wdata !== 8'd8 || bus.dmem_we !== 1'b1) bad++;
      end
    end
    chk("sw_req_cycles", req_cnt, 4);
    chk("sw_bus_unstable", bad, 0);
    ready_delay = 0;

    wait_done(11);
    rdreg(6, v); chk("R6_lw", v, 8);
    chk("lat_sw_wait3", done_cyc[9] - done_cyc[8], 7);
    chk("lat_lw", done_cyc[10] - done_cyc[9], 5);
    wait_done(12);
    chk("pc_beq_ne", done_pc[11], 12);
    chk("lat_beq", done_cyc[11] - done_cyc[10], 3);
    wait_done(13);
    rdreg(0, v); chk("R0_zero", v, 0);
    chk("lat_addi", done_cyc[12] - done_cyc[11], 4);
    wait_done(14);
    chk("illegal_set", illegal, 1);
    chk("pc_illegal", done_pc[13], 14);
    chk("lat_illegal", done_cyc[13] - done_cyc[12], 2);
    rdreg(7, v); chk("R7_kept", v, 'h3C);
    rdreg(1, v); chk("R1_kept", v, 5);
    wait_done(15);
    chk("pc_j", done_pc[14], 'h2A);
    chk("lat_j", done_cyc[14] - done_cyc[13], 2);
    wait_done(17);
    chk("pc_beq_loop0", done_pc[15], 'h2A);
    chk("pc_beq_loop1", done_pc[16], 'h2A);
    chk("lat_beq_eq", done_cyc[16] - done_cyc[15], 3);
    chk("illegal_sticky", illegal, 1);

    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst2_pc", pc_out, 0);
    chk("rst2_state", state_out, 0);
    chk("rst2_illegal", illegal, 0);
    acc = 0;
    for (int r = 0; r < 8; r++) begin rdreg(r, v); acc = acc | v; end
    chk("rst2_regs", acc, 0);

    rom[0]    = 32'h080000FF;                     // j 0xFF
    rom[8'hFF] = enc_i(6'b001000, 0, 1, 1);       // addi R1,R0,1
    base = ndone;
    @(negedge clk);
    rst = 1'b1;
    wait_done(base + 1);
    chk("pc_j_ff", pc_out, 'hFF);
    rom[0] = enc_i(6'b101011, 0, 1, 0);           // sw R1,0(R0)
    hold_ready = 1'b1;
    wait_done(base + 2);
    chk("pc_wrap", pc_out, 0);
    rdreg(1, v); chk("R1_wrap", v, 1);
    for (int n = 0; n < 20 && !bus.dmem_req; n++) @(negedge clk);
    @(negedge clk);
    chk("mem_req_held", bus.dmem_req, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_req", bus.dmem_req, 0);
    chk("rst_mem_pc", pc_out, 0);
    chk("rst_mem_state", state_out, 0);
    rdreg(1, v); chk("rst_mem_R1", v, 0);

    dbg_ra2 = 4'd15;
    #1;
    chk("n16_R15", 32'(dbg_rd2), 'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
Parametrised multi-cycle MIPS-subset processor core. It replaces the single-cycle datapath with an FSM-sequenced datapath: one ALU, registered IR/A/B/ALUOut/MDR. It has a fixed 1-cycle-latency instruction ROM port and a data-memory port with a req/ready handshake, so it tolerates variable-latency RAM. Debug ports expose registers, PC and state to the board-level displays/LEDs.

Parameters:
N, 8, data/register width in bits (>=4)
NREG, 8, number of architectural registers (power of 2, 2..32); R0 reads as zero
PC_W, 8, program counter / instruction address width (word addressed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
imem_addr  output  PC_W  instruction address; ROM registers it, data valid next cycle
imem_rdata  input  32  instruction word
dmem_req  output  1  data access request
dmem_we  output  1  1=store, 0=load (valid while dmem_req)
dmem_addr  output  N  data address (ALUOut)
dmem_wdata  output  N  store data (B register)
dmem_rdata  input  N  load data, valid in cycle dmem_ready=1
dmem_ready  input  1  access completes this cycle
dbg_ra  input  $clog2(NREG)  debug register select
dbg_rd  output  N  combinational read of register dbg_ra
pc_out  output  PC_W  current PC
state_out  output  3  FSM state encoding
instr_done  output  1  1-cycle pulse when an instruction retires
illegal  output  1  sticky: unknown opcode/funct decoded

Behaviour:
- Reset (clk edge with rst=0): PC=0, state=FETCH, all registers/IR/A/B/ALUOut/MDR=0, illegal=0, instr_done=0, dmem_req=0. Reset mid-MEM drops dmem_req on the next edge; the access is abandoned.
- ISA (32-bit MIPS encoding): R-type op=000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000; lw 100011; sw 101011; beq 000100; j 000010.
- Register index = low $clog2(NREG) bits of rs/rt/rd. Writes to R0 are ignored.
- Immediate = imm16 sign-extended/truncated to N bits. ALU wraps mod 2^N. slt is a signed compare that yields 1 or 0.
- ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- imem_addr = PC in every state.
- FETCH (1 cycle): go to DECODE.
- DECODE (1 cycle): IR<=imem_rdata; A<=R[rs], B<=R[rt], both read from the imem_rdata fields.
  - j: PC<=instr[PC_W-1:0], instr_done=1, go to FETCH.
  - Illegal: illegal<=1, PC<=PC+1, instr_done=1, go to FETCH (treated as NOP).
  - Otherwise go to EXEC.
- EXEC (1 cycle): ALUOut<=A op (B or imm).
  - beq: if A==B then PC<=PC+1+imm[PC_W-1:0] else PC<=PC+1; instr_done=1; go to FETCH.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM (>=1 cycle): dmem_req=1; dmem_addr, dmem_we, dmem_wdata held stable until dmem_ready=1.
  - On ready with lw: MDR<=dmem_rdata, go to WB.
  - On ready with sw: PC<=PC+1, instr_done=1, go to FETCH.
  - dmem_ready outside MEM is ignored.
- WB (1 cycle): R[rd] (R-type) or R[rt] (addi/lw) <= ALUOut (or MDR for lw); PC<=PC+1; instr_done=1; go to FETCH.
- Latencies (zero-wait RAM): j 2, beq 3, R/addi 4, sw 4, lw 5 cycles. Each dmem wait cycle adds 1.
- PC increments wrap mod 2^PC_W. The branch target adder is also PC_W bits and wraps.
- A register written in WB is visible to the next instruction's DECODE, because WB completes before FETCH.
- state_out: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Decomposition:
- Package mc_cpu_pkg holds the state enum, opcode/funct localparams and the ALU-control enum.
- Sub-module mc_regfile: NREG x N, 2 async read ports + debug read port, 1 sync write port, synchronous active-low clear, R0 hardwired zero.
- The ALU and the FSM stay inline in the core.

Test Plan:
- addi R1,R0,5; addi R2,R0,3; add R3,R1,R2 -> R3=8; instr_done pulses at cycles 4, 8, 12; pc_out=3.
- sub R4,R2,R1 then slt R5,R4,R0 -> R4=0xFE (N=8), R5=1; and/or of 0xF0,0x3C -> 0x30/0xFC.
- sw R3,2(R0) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, addr=2, wdata=8, we=1 stable. Then lw R6,2(R0) with ready immediate (RAM model returns the value written, 8) -> R6=8, 5-cycle latency.
- beq R1,R1,-1 at PC=10 -> PC=10 (loops); beq with unequal operands -> PC=11; j 0x2A -> PC=0x2A after 2 cycles; PC=0xFF then addi -> PC wraps to 0x00.
- Opcode 111111 -> illegal=1 and stays set, PC+1, no register changes. addi R0,R0,7 -> R0 still 0.
- rst=0 asserted during MEM wait -> next edge: dmem_req=0, PC=0, state_out=0, all registers 0. Rerun with N=16, NREG=16: addi R15,R0,-2 -> R15=0xFFFE.
